// File: rtl/cam_regfile_pkg.sv
// Purpose: shared types and constants for the camera configuration register file.
// Latency: none, declarations only.
// Backpressure: not applicable.
package cam_regfile_pkg;

    typedef enum logic [2:0] {
        W_IDLE,
        W_DATA,
        W_ADDR,
        W_EXEC,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_RESP
    } rd_state_t;

    localparam logic [1:0] AXI_OKAY   = 2'b00;
    localparam logic [1:0] AXI_SLVERR = 2'b10;

    localparam int CTRL_IDX        = 0;
    localparam int CTRL_COMMIT_BIT = 0;
    localparam int CTRL_IMM_BIT    = 1;

endpackage

// File: rtl/axil_write_collect.sv
// Purpose: gathers AXI-Lite AW and W beats (any order) into one exec pulse and owns the B channel.
// Latency: both beats captured at cycle T -> exec during T+1 -> bvalid from T+2.
// Backpressure: one write in flight; AW/W stall until the B beat is taken with bready.
// Ports: aw*/w*/b* AXI-Lite write channels; exec + exec_addr/data/strb to the register array;
//        exec_err from the register array decides the bresp latched at exec.
module axil_write_collect
    import cam_regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    output logic                  exec,
    output logic [ADDR_WIDTH-1:0] exec_addr,
    output logic [31:0]           exec_data,
    output logic [3:0]            exec_strb,
    input  logic                  exec_err
);

    wr_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           data_q;
    logic [3:0]            strb_q;
    logic [1:0]            bresp_q;

    always_comb begin
        state_d = state_q;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        exec    = 1'b0;
        case (state_q)
            W_IDLE: begin
                awready = 1'b1;
                wready  = 1'b1;
                if (awvalid && wvalid) state_d = W_EXEC;
                else if (awvalid)      state_d = W_DATA;
                else if (wvalid)       state_d = W_ADDR;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid) state_d = W_EXEC;
            end
            W_ADDR: begin
                awready = 1'b1;
                if (awvalid) state_d = W_EXEC;
            end
            W_EXEC: begin
                exec    = 1'b1;
                state_d = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) state_d = W_IDLE;
            end
            default: state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= W_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            bresp_q <= AXI_OKAY;
        end else begin
            state_q <= state_d;
            if (awvalid && awready) addr_q <= awaddr;
            if (wvalid && wready) begin
                data_q <= wdata;
                strb_q <= wstrb;
            end
            if (exec) bresp_q <= exec_err ? AXI_SLVERR : AXI_OKAY;
        end
    end

    assign bresp     = bresp_q;
    assign exec_addr = addr_q;
    assign exec_data = data_q;
    assign exec_strb = strb_q;

endmodule

// File: rtl/cam_config_regfile.sv
// Purpose: AXI-Lite camera config registers; staged writes commit atomically at frame_start.
// Latency: write handshake T -> staging at end of T+1, bvalid T+2; read handshake T -> rvalid T+2.
// Backpressure: one write and one read in flight, independently; channels stall until B/R taken.
// Ports: s_axi_lite_* AXI-Lite slave; frame_start SOF pulse; status_in read-only words;
//        cfg_active committed config; cfg_commit pulse with each active update; commit_pending.
module cam_config_regfile
    import cam_regfile_pkg::*;
#(
    parameter int NUM_REGS   = 16,
    parameter int NUM_RO     = 2,
    parameter int ADDR_WIDTH = 8,
    parameter logic [(NUM_REGS-NUM_RO)*32-1:0] RESET_VALUES = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDR_WIDTH-1:0]        s_axi_lite_awaddr,
    input  logic                         s_axi_lite_awvalid,
    output logic                         s_axi_lite_awready,
    input  logic [31:0]                  s_axi_lite_wdata,
    input  logic [3:0]                   s_axi_lite_wstrb,
    input  logic                         s_axi_lite_wvalid,
    output logic                         s_axi_lite_wready,
    output logic [1:0]                   s_axi_lite_bresp,
    output logic                         s_axi_lite_bvalid,
    input  logic                         s_axi_lite_bready,
    input  logic [ADDR_WIDTH-1:0]        s_axi_lite_araddr,
    input  logic                         s_axi_lite_arvalid,
    output logic                         s_axi_lite_arready,
    output logic [31:0]                  s_axi_lite_rdata,
    output logic [1:0]                   s_axi_lite_rresp,
    output logic                         s_axi_lite_rvalid,
    input  logic                         s_axi_lite_rready,
    input  logic                         frame_start,
    input  logic [NUM_RO*32-1:0]         status_in,
    output logic [(NUM_REGS-NUM_RO)*32-1:0] cfg_active,
    output logic                         cfg_commit,
    output logic                         commit_pending
);

    localparam int NUM_RW = NUM_REGS - NUM_RO;
    localparam int IDXW   = $clog2(NUM_REGS);

    // Word index of a byte address, or -1 when any bit above the index field is set
    // or the index lands past the last implemented word.
    function automatic int word_index(input logic [ADDR_WIDTH-1:0] a);
        int idx;
        if ((a >> (2 + IDXW)) != '0) return -1;
        idx = int'(a[2 +: IDXW]);
        if (idx >= NUM_REGS) return -1;
        return idx;
    endfunction

    logic [31:0]           staging    [NUM_RW];
    logic [31:0]           staging_wr [NUM_RW];
    logic [31:0]           active     [NUM_RW];
    logic                  pending_q;
    logic                  exec, exec_err;
    logic [ADDR_WIDTH-1:0] exec_addr;
    logic [31:0]           exec_data;
    logic [3:0]            exec_strb;

    axil_write_collect #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr (
        .clk       (clk),
        .reset     (reset),
        .awaddr    (s_axi_lite_awaddr),
        .awvalid   (s_axi_lite_awvalid),
        .awready   (s_axi_lite_awready),
        .wdata     (s_axi_lite_wdata),
        .wstrb     (s_axi_lite_wstrb),
        .wvalid    (s_axi_lite_wvalid),
        .wready    (s_axi_lite_wready),
        .bresp     (s_axi_lite_bresp),
        .bvalid    (s_axi_lite_bvalid),
        .bready    (s_axi_lite_bready),
        .exec      (exec),
        .exec_addr (exec_addr),
        .exec_data (exec_data),
        .exec_strb (exec_strb),
        .exec_err  (exec_err)
    );

    // Write path: staging_wr is staging with the current exec write merged in.
    int   w_idx;
    logic w_ok, pend_set, imm_commit, frame_commit;

    always_comb begin
        w_idx      = word_index(exec_addr);
        w_ok       = (w_idx >= 0) && (w_idx < NUM_RW);
        staging_wr = staging;
        pend_set   = 1'b0;
        if (exec && w_ok) begin
            for (int i = 0; i < NUM_RW; i++) begin
                if (w_idx == i) begin
                    for (int b = 0; b < 4; b++) begin
                        if (exec_strb[b]) staging_wr[i][8*b +: 8] = exec_data[8*b +: 8];
                    end
                end
            end
            // COMMIT is an action, not storage: it only requests a commit.
            if (w_idx == CTRL_IDX) begin
                pend_set = exec_strb[0] && exec_data[CTRL_COMMIT_BIT];
                staging_wr[CTRL_IDX][CTRL_COMMIT_BIT] = 1'b0;
            end
        end
        // IMMEDIATE is taken from the post-write CTRL so setting it takes effect at once.
        imm_commit   = exec && w_ok && staging_wr[CTRL_IDX][CTRL_IMM_BIT];
        frame_commit = frame_start && pending_q;
    end

    assign exec_err = !w_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_RW; i++) begin
                staging[i] <= RESET_VALUES[32*i +: 32];
                active[i]  <= RESET_VALUES[32*i +: 32];
            end
            pending_q  <= 1'b0;
            cfg_commit <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_RW; i++) begin
                staging[i] <= staging_wr[i];
                // A frame commit racing a write takes the pre-write staging; the write stays staged.
                if (imm_commit)        active[i] <= staging_wr[i];
                else if (frame_commit) active[i] <= staging[i];
            end
            cfg_commit <= imm_commit || frame_commit;
            // A COMMIT written in the commit cycle re-arms pending for the next frame.
            if (frame_commit) pending_q <= pend_set;
            else if (pend_set) pending_q <= 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_RW; i++) cfg_active[32*i +: 32] = active[i];
    end

    assign commit_pending = pending_q;

    // Read path.
    rd_state_t             rstate_q, rstate_d;
    logic [ADDR_WIDTH-1:0] raddr_q;
    logic [31:0]           rdata_q, rd_word;
    logic [1:0]            rresp_q;
    int                    r_idx;

    always_comb begin
        rstate_d           = rstate_q;
        s_axi_lite_arready = 1'b0;
        s_axi_lite_rvalid  = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                s_axi_lite_arready = 1'b1;
                if (s_axi_lite_arvalid) rstate_d = R_FETCH;
            end
            R_FETCH: rstate_d = R_RESP;
            R_RESP: begin
                s_axi_lite_rvalid = 1'b1;
                if (s_axi_lite_rready) rstate_d = R_IDLE;
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_comb begin
        r_idx   = word_index(raddr_q);
        rd_word = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            if (r_idx == i) rd_word = staging[i];
        end
        if (r_idx == CTRL_IDX) rd_word[CTRL_COMMIT_BIT] = pending_q;
        for (int k = 0; k < NUM_RO; k++) begin
            if (r_idx == NUM_RW + k) rd_word = status_in[32*k +: 32];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rstate_q <= R_IDLE;
            raddr_q  <= '0;
            rdata_q  <= '0;
            rresp_q  <= AXI_OKAY;
        end else begin
            rstate_q <= rstate_d;
            if (s_axi_lite_arvalid && s_axi_lite_arready) raddr_q <= s_axi_lite_araddr;
            if (rstate_q == R_FETCH) begin
                rdata_q <= rd_word;
                rresp_q <= (r_idx < 0) ? AXI_SLVERR : AXI_OKAY;
            end
        end
    end

    assign s_axi_lite_rdata = rdata_q;
    assign s_axi_lite_rresp = rresp_q;

endmodule
